// File: rtl/fft_pkg.sv
// Shared constants and helpers for the radix-2 FFT datapath.
// A complex sample packs the real part in the upper half and the imaginary part in the lower half.
package fft_pkg;

  localparam int FFT_FLOAT_LEN = 32;
  localparam int FFT_CPLX_W    = 2 * FFT_FLOAT_LEN;

  // Constant-foldable ceil(log2(v)); used for elaboration-time parameter checks.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_buf_ram.sv
// Simple dual-port RAM holding the first half of a block: one write port and one registered read port.
// There is no reset, so the array and the read register map onto block RAM or LUT RAM.
module pair_buf_ram #(
  parameter int W        = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [W-1:0]        wr_dat,
  input  logic                rd_en,
  input  logic [ADDR_LEN-1:0] rd_addr,
  output logic [W-1:0]        rd_dat
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/pair_delay_buffer.sv
// Pairs sample k with sample k+DEPTH of each 2*DEPTH block for the butterfly; 1-cycle latency, no backpressure.
// Optional macro OUT_INDEX_EN adds the registered pair index port out_idx.
module pair_delay_buffer
  import fft_pkg::*;
#(
  parameter int FLOAT_LEN = FFT_FLOAT_LEN,
  parameter int ADDR_LEN  = 5,
  parameter int DEPTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync_clr,
  input  logic [2*FLOAT_LEN-1:0] data_in,
  input  logic                   data_in_valid,
  output logic [2*FLOAT_LEN-1:0] data_out1,
  output logic [2*FLOAT_LEN-1:0] data_out2,
  output logic                   data_out_valid,
  output logic                   data_out_last
`ifdef OUT_INDEX_EN
  ,
  output logic [ADDR_LEN-1:0]    out_idx
`endif
);

  localparam int                W       = 2 * FLOAT_LEN;
  localparam logic [ADDR_LEN:0] CNT_ONE = 1;
  localparam logic [ADDR_LEN-1:0] LAST_K = ADDR_LEN'(DEPTH - 1);

  if (DEPTH != (1 << ADDR_LEN) || clog2(DEPTH) != ADDR_LEN) begin : g_bad_depth
    $error("pair_delay_buffer: DEPTH must equal 2**ADDR_LEN");
  end

  logic [ADDR_LEN:0]   cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic [W-1:0]        out2_q, out2_d;
  logic                rd_seen_q, rd_seen_d;
  logic                accept, wr_en, rd_en;
  logic [ADDR_LEN-1:0] addr;
  logic [W-1:0]        rd_dat;

  // Top counter bit selects the phase; the low bits address the RAM in both phases.
  assign addr   = cnt_q[ADDR_LEN-1:0];
  assign accept = data_in_valid & ~sync_clr;
  assign wr_en  = accept & ~cnt_q[ADDR_LEN];
  assign rd_en  = accept &  cnt_q[ADDR_LEN];

  pair_buf_ram #(
    .W        (W),
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_dat  (data_in),
    .rd_en   (rd_en),
    .rd_addr (addr),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    cnt_d     = cnt_q;
    vld_d     = rd_en;
    last_d    = rd_en && (addr == LAST_K);
    out2_d    = out2_q;
    rd_seen_d = rd_seen_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (data_in_valid) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    if (rd_en) begin
      out2_d    = data_in;
      rd_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      out2_q    <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      out2_q    <= out2_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  // The RAM read register has no reset, so x1 reads as zero until the first pair after reset.
  assign data_out1      = rd_seen_q ? rd_dat : '0;
  assign data_out2      = out2_q;
  assign data_out_valid = vld_q;
  assign data_out_last  = last_q;

`ifdef OUT_INDEX_EN
  logic [ADDR_LEN-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (rd_en) idx_d = addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx_q <= '0;
    else      idx_q <= idx_d;
  end

  assign out_idx = idx_q;
`endif

endmodule

// File: tb/tb_pair_delay_buffer.sv
// Directed-vector bench: a DEPTH=4 instance for pairing, gaps, sync_clr and reset cases,
// plus a DEPTH=32 instance for a full 64-sample block.
module tb_pair_delay_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_clr = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [63:0] data_in = '0;

  logic [63:0] o1_4, o2_4, o1_32, o2_32;
  logic        vld_4, last_4, vld_32, last_32;
  logic [1:0]  idx_4;
  logic [4:0]  idx_32;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] e1, e2;

  always #5 clk = ~clk;

  pair_delay_buffer #(.FLOAT_LEN(32), .ADDR_LEN(2), .DEPTH(4)) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .sync_clr       (sync_clr),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out1      (o1_4),
    .data_out2      (o2_4),
    .data_out_valid (vld_4),
    .data_out_last  (last_4)
`ifdef OUT_INDEX_EN
    ,
    .out_idx        (idx_4)
`endif
  );

  pair_delay_buffer #(.FLOAT_LEN(32), .ADDR_LEN(5), .DEPTH(32)) u_dut32 (
    .clk            (clk),
    .rst            (rst),
    .sync_clr       (sync_clr),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out1      (o1_32),
    .data_out2      (o2_32),
    .data_out_valid (vld_32),
    .data_out_last  (last_32)
`ifdef OUT_INDEX_EN
    ,
    .out_idx        (idx_32)
`endif
  );

`ifndef OUT_INDEX_EN
  assign idx_4  = '0;
  assign idx_32 = '0;
`endif

  function automatic logic [63:0] mk(input int r);
    return {32'(r), 32'(r + 1000)};
  endfunction

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input for one clock; return 1 time unit after the edge.
  task automatic drive(input logic v, input int r, input logic c);
    data_in       = mk(r);
    data_in_valid = v;
    sync_clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string tag, input logic v, input logic l,
                         input logic [63:0] a, input logic [63:0] b, input int k);
    check_vec({tag, "_vld"},  {63'd0, vld_4},  {63'd0, v});
    check_vec({tag, "_last"}, {63'd0, last_4}, {63'd0, l});
    check_vec({tag, "_x1"},   o1_4, a);
    check_vec({tag, "_x2"},   o2_4, b);
`ifdef OUT_INDEX_EN
    if (v) check_vec({tag, "_idx"}, {62'd0, idx_4}, 64'(k));
`endif
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check_vec("rst_vld",  {63'd0, vld_4},  64'd0);
    check_vec("rst_last", {63'd0, last_4}, 64'd0);
    check_vec("rst_x1",   o1_4, 64'd0);
    check_vec("rst_x2",   o2_4, 64'd0);
    check_vec("rst_idx",  {62'd0, idx_4}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Continuous valid, one block.
    e1 = '0; e2 = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 1'b0);
      if (i >= 4) begin e1 = mk(i - 4); e2 = mk(i); end
      expect4("t1", i >= 4, i == 7, e1, e2, i - 4);
    end
    drive(1'b0, 0, 1'b0);
    expect4("t1_idle", 1'b0, 1'b0, e1, e2, 0);

    // Valid every other cycle: pulses only after second-half samples, held in gaps.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 1'b0);
      if (i >= 4) begin e1 = mk(i - 4); e2 = mk(i); end
      expect4("t2", i >= 4, i == 7, e1, e2, i - 4);
      drive(1'b0, 55, 1'b0);
      expect4("t2_gap", 1'b0, 1'b0, e1, e2, 0);
    end

    // Two back-to-back blocks.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i, 1'b0);
      if ((i % 8) >= 4) begin e1 = mk(i - 4); e2 = mk(i); end
      expect4("t3", (i % 8) >= 4, (i % 8) == 7, e1, e2, (i % 8) - 4);
    end

    // sync_clr mid-block drops the coincident sample and realigns.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 1'b0);
      expect4("t4_pre", 1'b0, 1'b0, e1, e2, 0);
    end
    drive(1'b1, 99, 1'b1);
    expect4("t4_clr", 1'b0, 1'b0, e1, e2, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 100 + i, 1'b0);
      if (i >= 4) begin e1 = mk(96 + i); e2 = mk(100 + i); end
      expect4("t4", i >= 4, i == 7, e1, e2, i - 4);
    end

    // Asynchronous reset after pair (1,5).
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i, 1'b0);
      if (i >= 4) begin e1 = mk(i - 4); e2 = mk(i); end
      expect4("t5_pre", i >= 4, 1'b0, e1, e2, i - 4);
    end
    #2 rst = 1'b0;
    #1;
    e1 = '0; e2 = '0;
    expect4("t5_rst", 1'b0, 1'b0, e1, e2, 0);
    check_vec("t5_rst_idx", {62'd0, idx_4}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 20 + i, 1'b0);
      if (i >= 4) begin e1 = mk(16 + i); e2 = mk(20 + i); end
      expect4("t5", i >= 4, i == 7, e1, e2, i - 4);
    end

    // Full 64-sample block through the DEPTH=32 instance.
    drive(1'b0, 0, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, i, 1'b0);
      check_vec("t6_vld",  {63'd0, vld_32},  {63'd0, i >= 32});
      check_vec("t6_last", {63'd0, last_32}, {63'd0, i == 63});
      if (i >= 32) begin
        check_vec("t6_x1", o1_32, mk(i - 32));
        check_vec("t6_x2", o2_32, mk(i));
`ifdef OUT_INDEX_EN
        check_vec("t6_idx", {59'd0, idx_32}, 64'(i - 32));
`endif
      end
    end
    drive(1'b0, 0, 1'b0);
    check_vec("t6_idle_vld", {63'd0, vld_32}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pair_delay_buffer.md
Name: pair_delay_buffer

Overview:
- Parametrised successor of the fixed 32-deep pairing FIFO used by the radix-2 stages.
- Splits each incoming block of 2*DEPTH complex samples into two halves.
- Stores the first half; on the second half, emits pairs (x1 = sample k, x2 = sample k+DEPTH) to the butterfly.
- Fully synchronous control: counter-based, no full/empty edge logic; tolerates gaps in data_in_valid; re-alignable mid-stream.

Parameters:
- FLOAT_LEN, 32, width of one float component; complex sample = 2*FLOAT_LEN bits (real in upper half).
- ADDR_LEN, 5, log2 of DEPTH.
- DEPTH, 32, samples per half-block; must equal 2**ADDR_LEN (elaboration-time check).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- sync_clr  in  1  synchronous restart of block alignment.
- data_in  in  2*FLOAT_LEN  input complex sample.
- data_in_valid  in  1  data_in is a valid sample this cycle.
- data_out1  out  2*FLOAT_LEN  x1, the buffered first-half sample k.
- data_out2  out  2*FLOAT_LEN  x2, the current second-half sample k+DEPTH.
- data_out_valid  out  1  pair valid, one-cycle pulse per pair.
- data_out_last  out  1  high with data_out_valid on pair k = DEPTH-1.
- out_idx  out  ADDR_LEN  pair index k (only when OUT_INDEX_EN is defined).

Behaviour:
- Reset (rst=0, async):
  - cnt=0; data_out1=0, data_out2=0, data_out_valid=0, data_out_last=0, out_idx=0.
  - RAM contents are not reset.
- cnt is ADDR_LEN+1 bits. It advances by 1 on each cycle with data_in_valid=1 and sync_clr=0, and wraps 2*DEPTH-1 -> 0. It holds when data_in_valid=0.
- Phase A (cnt[ADDR_LEN]=0): write data_in into ram[cnt[ADDR_LEN-1:0]]. No output; data_out_valid=0 next cycle.
- Phase B (cnt[ADDR_LEN]=1), with a valid input:
  - Read ram[cnt[ADDR_LEN-1:0]] via a registered read port.
  - Next cycle: data_out1 = RAM word, data_out2 = registered data_in, data_out_valid=1.
  - data_out_last=1 when cnt low bits = DEPTH-1.
- Latency: exactly 1 cycle from the accepted second-half sample to its pair on the outputs.
- Throughput: 1 pair per valid second-half sample; no backpressure.
- Write and read addresses never coincide in the same cycle (different phases), so no RAM collision rule is needed.
- data_out1/data_out2 hold their last values while data_out_valid=0; data_out_valid never stays high without a new valid input.
- sync_clr=1:
  - cnt <= 0; data_out_valid and data_out_last <= 0 next cycle.
  - A sample presented in the same cycle is dropped (sync_clr has priority).
  - The next valid sample is sample 0 of a new block; stale RAM data is never emitted before it is overwritten.
- Reset mid-block: outputs clear immediately; after release the next valid sample is sample 0.
- Back-to-back blocks: the first-half write of block n+1 directly follows the last pair of block n, with no dead cycles.

Optional Feature:
- Macro OUT_INDEX_EN.
- Defined: out_idx port exists. It is registered alongside data_out_valid and carries k (0..DEPTH-1) for twiddle-ROM addressing; reset value 0; holds when not valid.
- Undefined: out_idx port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package fft_pkg:
  - FLOAT_LEN default.
  - Complex sample width constant (2*FLOAT_LEN).
  - clog2 function used for the DEPTH/ADDR_LEN check.
- One sub-module, pair_buf_ram:
  - Simple dual-port RAM, DEPTH x 2*FLOAT_LEN.
  - One write port, one registered read port, no reset, BRAM/LUTRAM inferable.

Test Plan:
- DEPTH=4, continuous valid, samples 0..7 (real part = index) -> pairs (0,4),(1,5),(2,6),(3,7) on the 4 cycles each 1 cycle after inputs 4..7; data_out_last only on (3,7).
- DEPTH=4, same data with valid every other cycle -> identical pairs; data_out_valid high exactly 1 cycle after each of samples 4..7, low otherwise; outputs held during gaps.
- DEPTH=4, continuous samples 0..15 -> pairs (0,4)..(3,7), then (8,12)..(11,15); no bubble between blocks, last asserted twice.
- DEPTH=4, feed 0,1,2, assert sync_clr with sample 99, then feed 100..107 -> 99 dropped; pairs (100,104)..(103,107).
- DEPTH=4, drive rst=0 asynchronously after pair (1,5), then release and feed 20..27 -> all outputs 0 immediately; next pairs (20,24)..(23,27).
- OUT_INDEX_EN defined, DEPTH=32, samples 0..63 -> out_idx 0..31 aligned with pairs (k,k+32); data_out_last with out_idx=31.
